// File: rtl/div_iter_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative divider.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // EX stage side: issues the operation, observes stall and the result
    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  stall, ready, quotient, remainder
    );

    // Divider side
    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output stall, ready, quotient, remainder
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle. Signed division is done
// on magnitudes with the result signs fixed up when the last bit is produced.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] q_reg;          // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_reg;        // running partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] dmag_reg;
    logic             qneg_reg, rneg_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;

    logic             accept;
    logic             stall, ready;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH:0]   partial;
    logic             ge;
    logic [WIDTH-1:0] diff, rem_step, q_step, quot_final, rem_final;

    assign accept = bus.start && !bus.annul;

    // Magnitudes: the most negative value maps onto itself, which is correct as unsigned
    assign dividend_mag = (bus.signed_div && bus.dividend[WIDTH-1]) ? (~bus.dividend + ONE) : bus.dividend;
    assign divisor_mag  = (bus.signed_div && bus.divisor[WIDTH-1])  ? (~bus.divisor + ONE)  : bus.divisor;

    // One restoring step. The compare is WIDTH+1 bits wide so the shifted remainder
    // never overflows; the difference itself always fits in WIDTH bits.
    assign partial  = {rem_reg, q_reg[WIDTH-1]};
    assign ge       = partial >= {1'b0, dmag_reg};
    assign diff     = partial[WIDTH-1:0] - dmag_reg;
    assign rem_step = ge ? diff : partial[WIDTH-1:0];
    assign q_step   = {q_reg[WIDTH-2:0], ge};

    // Sign fix-up applied to the final step's outputs (two's complement wrap allowed)
    assign quot_final = qneg_reg ? (~q_step + ONE)   : q_step;
    assign rem_final  = rneg_reg ? (~rem_step + ONE) : rem_step;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; annul squashes any in-flight work
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = (bus.divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (bus.annul) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            ZERO: begin
                stall      = 1'b1;
                state_next = bus.annul ? IDLE : DONE;
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result write on completion only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            q_reg         <= '0;
            rem_reg       <= '0;
            dmag_reg      <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg  <= CW'(WIDTH);
                        rem_reg  <= '0;
                        dmag_reg <= divisor_mag;
                        qneg_reg <= bus.signed_div && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        rneg_reg <= bus.signed_div && bus.dividend[WIDTH-1];
                        // Divide-by-zero reports the raw dividend as remainder
                        q_reg    <= (bus.divisor == '0) ? bus.dividend : dividend_mag;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    q_reg   <= q_step;
                    rem_reg <= rem_step;
                    if (!bus.annul && cnt_reg == CW'(1)) begin
                        quotient_reg  <= quot_final;
                        remainder_reg <= rem_final;
                    end
                end
                ZERO: begin
                    if (!bus.annul) begin
                        quotient_reg  <= '1;
                        remainder_reg <= q_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall     = stall;
    assign bus.ready     = ready;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: expected results are queued when a division is
// issued and compared when ready pulses; latency, stall, annul and reset are checked inline.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int ready_cnt = 0;
    int n_div     = 0;
    logic [63:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: {quotient, remainder}
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic signed [31:0] sa, sb_, sq, sr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
            sa = a; sb_ = b;
            sq = sa / sb_;
            sr = sa % sb_;
            return {sq, sr};
        end
        return {a / b, a % b};
    endfunction

    // Result monitor: one line per completed division
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.ready) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e[63:32]);
                check("remainder", bus.remainder, e[31:0]);
                $display("div result q=%h r=%h (exp q=%h r=%h)", bus.quotient, bus.remainder, e[63:32], e[31:0]);
            end
        end
    end

    // Issue one division and hold start (as EX would) until ready; optionally
    // change the operands mid-operation to show they are only sampled at accept.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input int exp_lat, input bit perturb, input string tag);
        int lat = -1;
        int stall_low = 0;
        sb.push_back(model(a, b, sg));
        n_div++;
        @(posedge clk); #1;
        bus.dividend = a; bus.divisor = b; bus.signed_div = sg; bus.start = 1'b1;
        for (int c = 0; c < 100 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = c;
                check({tag, "_stall_in_ready"}, {31'd0, bus.stall}, 32'd0);
            end else if (!bus.stall) begin
                stall_low++;
            end
            if (lat < 0) begin
                @(posedge clk); #1;
                if (perturb && c == 4) begin
                    bus.dividend = 32'd999; bus.divisor = 32'd5;
                end
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall_held"}, stall_low, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, {31'd0, bus.ready}, 32'd0);
        check({tag, "_stall_after"}, {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        int base;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.dividend = '0; bus.divisor = '0;

        // Reset state
        #12;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_q", bus.quotient, 32'd0);
        check("rst_r", bus.remainder, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Main function and boundaries
        run_div(32'd100,        32'd7,          1'b0, 33, 1'b0, "divu_100_7");
        run_div(32'hFFFF_FFF9,  32'd2,          1'b1, 33, 1'b0, "div_m7_2");
        run_div(32'd7,          32'hFFFF_FFFE,  1'b1, 33, 1'b0, "div_7_m2");
        run_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 33, 1'b0, "div_min_m1");
        run_div(32'hFFFF_FFFF,  32'd1,          1'b0, 33, 1'b0, "divu_max_1");
        run_div(32'd0,          32'd5,          1'b1, 33, 1'b0, "div_zero_dividend");
        run_div(32'd3,          32'd10,         1'b0, 33, 1'b0, "divu_small");
        run_div(32'h0000_1234,  32'd0,          1'b0, 2,  1'b0, "divu_by_zero");

        // start together with annul in IDLE is not accepted
        @(posedge clk); #1;
        bus.dividend = 32'd50; bus.divisor = 32'd3; bus.signed_div = 1'b0;
        bus.start = 1'b1; bus.annul = 1'b1;
        @(negedge clk);
        check("idle_annul_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.annul = 1'b0;
        @(negedge clk);
        check("idle_annul_not_taken", {31'd0, bus.stall}, 32'd0);

        // Annul mid-CALC: no ready, results keep the divide-by-zero values
        base = ready_cnt;
        @(posedge clk); #1;
        bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        bus.annul = 1'b1;
        @(negedge clk);
        check("annul_stall_cycle10", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.annul = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("annul_idle_stall", {31'd0, bus.stall}, 32'd0);
        check("annul_q_kept", bus.quotient, 32'hFFFF_FFFF);
        check("annul_r_kept", bus.remainder, 32'h0000_1234);
        repeat (25) @(negedge clk);
        check("annul_no_ready", ready_cnt - base, 32'd0);
        run_div(32'd100, 32'd7, 1'b0, 33, 1'b1, "after_annul");

        // Asynchronous reset between edges mid-CALC
        @(posedge clk); #1;
        bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1; bus.start = 1'b0;
        #1;
        check("arst_stall", {31'd0, bus.stall}, 32'd0);
        check("arst_ready", {31'd0, bus.ready}, 32'd0);
        check("arst_q", bus.quotient, 32'd0);
        check("arst_r", bus.remainder, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 33, 1'b0, "divu_9_3");

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("ready_count", ready_cnt, n_div);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
